life_step_engine: RTL

Sequential next-generation engine for the 16x16 toroidal Game of Life map. It sits directly upstream of the map register in `game_of_life`. On each generation tick it snapshots the current 256-bit map and sweeps one row per clock. It then delivers the complete next map atomically, together with a population count and a generation counter. It replaces the 256 parallel neighbour adders with one 16-cell row datapath.

---
 rtl/life_step_engine.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/life_step_engine.sv
// Row-serial next-generation engine for a 16x16 toroidal Game of Life map.
// Snapshots the map on start, sweeps one row per clock, then publishes map, population and generation count together.
module life_step_engine #(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] map_in,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] map_out,
    output logic [8:0]           population,
    output logic [15:0]          gen_count
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // One output row: 4-bit indices make column wrap-around fall out of modulo-16 arithmetic.
    function automatic logic [15:0] life_row(input logic [15:0] n_row,
                                             input logic [15:0] c_row,
                                             input logic [15:0] s_row);
        logic [15:0] res;
        logic [3:0]  cnt;
        logic [3:0]  w;
        logic [3:0]  k4;
        logic [3:0]  e;
        res = 16'd0;
        for (int k = 0; k < 16; k++) begin
            k4  = 4'(k);
            w   = k4 - 4'd1;
            e   = k4 + 4'd1;
            cnt = {3'd0, n_row[w]} + {3'd0, n_row[k4]} + {3'd0, n_row[e]}
                + {3'd0, c_row[w]}                      + {3'd0, c_row[e]}
                + {3'd0, s_row[w]} + {3'd0, s_row[k4]} + {3'd0, s_row[e]};
            res[k4] = (cnt == 4'd3) || (c_row[k4] && (cnt == 4'd2));
        end
        return res;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] sum;
        sum = 5'd0;
        for (int k = 0; k < 16; k++) begin
            sum = sum + {4'd0, v[k]};
        end
        return sum;
    endfunction

    state_t                 state_q, state_d;
    logic [3:0]             row_q, row_d;
    logic [ROWS*COLS-1:0]   cur_q, cur_d;
    logic [ROWS*COLS-1:0]   nxt_q, nxt_d;
    logic [8:0]             pop_acc_q, pop_acc_d;
    logic [ROWS*COLS-1:0]   map_out_q, map_out_d;
    logic [8:0]             population_q, population_d;
    logic [15:0]            gen_count_q, gen_count_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [3:0]             north_idx_s;
    logic [3:0]             south_idx_s;
    logic [15:0]            row_res_s;
    logic [4:0]             row_pop_s;

    // Row datapath: neighbour rows wrap vertically through the 4-bit row index.
    always_comb begin
        north_idx_s = row_q - 4'd1;
        south_idx_s = row_q + 4'd1;
        row_res_s   = life_row(cur_q[{north_idx_s, 4'd0} +: 16],
                               cur_q[{row_q, 4'd0} +: 16],
                               cur_q[{south_idx_s, 4'd0} +: 16]);
        row_pop_s   = popcount16(row_res_s);
    end

    // Next-state and output-register logic for the IDLE/SWEEP controller.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        cur_d        = cur_q;
        nxt_d        = nxt_q;
        pop_acc_d    = pop_acc_q;
        map_out_d    = map_out_q;
        population_d = population_q;
        gen_count_d  = gen_count_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SWEEP;
                    cur_d     = map_in;
                    row_d     = 4'd0;
                    pop_acc_d = 9'd0;
                    busy_d    = 1'b1;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            ST_SWEEP: begin
                nxt_d[{row_q, 4'd0} +: 16] = row_res_s;
                pop_acc_d = pop_acc_q + {4'd0, row_pop_s};
                row_d     = row_q + 4'd1;
                if (row_q == 4'd15) begin
                    state_d      = ST_IDLE;
                    map_out_d    = nxt_d;
                    population_d = pop_acc_d;
                    gen_count_d  = gen_count_q + 16'd1;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                end else begin
                    busy_d       = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything and suppresses any pending done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            row_q        <= 4'd0;
            cur_q        <= '0;
            nxt_q        <= '0;
            pop_acc_q    <= 9'd0;
            map_out_q    <= '0;
            population_q <= 9'd0;
            gen_count_q  <= 16'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cur_q        <= cur_d;
            nxt_q        <= nxt_d;
            pop_acc_q    <= pop_acc_d;
            map_out_q    <= map_out_d;
            population_q <= population_d;
            gen_count_q  <= gen_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign map_out    = map_out_q;
    assign population = population_q;
    assign gen_count  = gen_count_q;

endmodule
